// File: rtl/rf_1p_msk.sv
// Single-port register file with per-lane write mask, 1- or 2-cycle read latency,
// read-valid flag and a sequential zero-fill engine run after reset or on clr_i.
module rf_1p_msk #(
    parameter int unsigned Word_Width = 32,
    parameter int unsigned Addr_Width = 8,
    parameter int unsigned Mask_Width = 4,
    parameter int unsigned Out_Reg    = 0,
    parameter int unsigned Init_En    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [Mask_Width-1:0] bwen_i,
    input  logic [Addr_Width-1:0] addr_i,
    input  logic [Word_Width-1:0] data_i,
    input  logic                  clr_i,
    output logic [Word_Width-1:0] data_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int unsigned LaneWidth = Word_Width / Mask_Width;
    localparam int unsigned Depth     = 1 << Addr_Width;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic [Addr_Width-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [Word_Width-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic [Word_Width-1:0]   mem_q [Depth];

    logic                    mem_we_c;
    logic [Addr_Width-1:0]   mem_waddr_c;
    logic [Word_Width-1:0]   mem_wdata_c;
    logic [Word_Width-1:0]   lane_mask_c;
    logic                    rd_en_c;
    logic                    rd_valid_c;
    logic [Word_Width-1:0]   rd_data_c;

    // Expand the active-low lane enables into a bit mask of lanes to overwrite.
    always_comb begin
        lane_mask_c = '0;
        for (int k = 0; k < int'(Mask_Width); k++) begin
            lane_mask_c[k*LaneWidth +: LaneWidth] = {LaneWidth{~bwen_i[k]}};
        end
    end

    // Next-state, clear engine and access decode. busy_q gates the fill so the
    // cycle right after reset only raises busy and the fill spans exactly Depth cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_i;
        mem_wdata_c = '0;
        rd_en_c     = 1'b0;
        case (state_q)
            ST_INIT: begin
                busy_d = 1'b1;
                if (busy_q) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = cnt_q;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == Addr_Width'(Depth - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_IDLE: begin
                busy_d  = 1'b0;
                rd_en_c = ~cen_i & wen_i;
                if (!cen_i && !wen_i) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = (mem_q[addr_i] & ~lane_mask_c) | (data_i & lane_mask_c);
                end
                if (clr_i && (Init_En != 0)) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
        endcase
    end

    // Storage array: no reset, contents are defined by the clear engine.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    if (Out_Reg != 0) begin : g_out_reg
        logic                  s1_valid_q, s1_valid_d;
        logic [Word_Width-1:0] s1_data_q, s1_data_d;

        always_comb begin
            s1_valid_d = rd_en_c;
            s1_data_d  = s1_data_q;
            if (rd_en_c) begin
                s1_data_d = mem_q[addr_i];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
            end
        end

        assign rd_valid_c = s1_valid_q;
        assign rd_data_c  = s1_data_q;
    end else begin : g_no_out_reg
        assign rd_valid_c = rd_en_c;
        assign rd_data_c  = mem_q[addr_i];
    end

    // Output stage holds the last result between reads.
    always_comb begin
        valid_d = rd_valid_c;
        data_d  = data_q;
        if (rd_valid_c) begin
            data_d = rd_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (Init_En != 0) ? ST_INIT : ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_rf_1p_msk.sv
// Directed bench for rf_1p_msk: three instances (latency 1, latency 2, no init engine)
// share one stimulus stream; each check targets the instance whose behaviour it covers.
module tb_rf_1p_msk;

    localparam int unsigned WW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          rst, cen, wen, clr;
    logic [MW-1:0] bwen;
    logic [AW-1:0] addr;
    logic [WW-1:0] din;
    logic [WW-1:0] d0, d1, d2;
    logic          v0, v1, v2, b0, b1, b2;

    int n_run  = 0;
    int n_fail = 0;
    int bc;

    always #5 clk = ~clk;

    rf_1p_msk #(.Word_Width(WW), .Addr_Width(AW), .Mask_Width(MW), .Out_Reg(0), .Init_En(1)) u0 (
        .clk(clk), .rst(rst), .cen_i(cen), .wen_i(wen), .bwen_i(bwen), .addr_i(addr),
        .data_i(din), .clr_i(clr), .data_o(d0), .valid_o(v0), .busy_o(b0));
    rf_1p_msk #(.Word_Width(WW), .Addr_Width(AW), .Mask_Width(MW), .Out_Reg(1), .Init_En(1)) u1 (
        .clk(clk), .rst(rst), .cen_i(cen), .wen_i(wen), .bwen_i(bwen), .addr_i(addr),
        .data_i(din), .clr_i(clr), .data_o(d1), .valid_o(v1), .busy_o(b1));
    rf_1p_msk #(.Word_Width(WW), .Addr_Width(AW), .Mask_Width(MW), .Out_Reg(0), .Init_En(0)) u2 (
        .clk(clk), .rst(rst), .cen_i(cen), .wen_i(wen), .bwen_i(bwen), .addr_i(addr),
        .data_i(din), .clr_i(clr), .data_o(d2), .valid_o(v2), .busy_o(b2));

    typedef struct {
        logic          cen;
        logic          wen;
        logic [MW-1:0] bwen;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        logic          exp_v;
        logic [WW-1:0] exp_d;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [MW-1:0] bw,
                         input logic [AW-1:0] a, input logic [WW-1:0] d);
        cen  = c;
        wen  = w;
        bwen = bw;
        addr = a;
        din  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Latency-1 instance: writes, masked writes, no-op writes, held data.
        vt[0]  = '{1'b0, 1'b0, 4'b0000, 4'd3, 32'hAABBCCDD, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 4'b1010, 4'd3, 32'h11223344, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 4'b1111, 4'd3, 32'h0,        1'b1, 32'hAA22CC44};
        vt[3]  = '{1'b1, 1'b1, 4'b1111, 4'd3, 32'h0,        1'b0, 32'hAA22CC44};
        vt[4]  = '{1'b0, 1'b0, 4'b1111, 4'd3, 32'hFFFFFFFF, 1'b0, 32'hAA22CC44};
        vt[5]  = '{1'b0, 1'b1, 4'b1111, 4'd3, 32'h0,        1'b1, 32'hAA22CC44};
        vt[6]  = '{1'b0, 1'b0, 4'b0000, 4'd7, 32'h12345678, 1'b0, 32'hAA22CC44};
        vt[7]  = '{1'b0, 1'b1, 4'b0000, 4'd7, 32'h0,        1'b1, 32'h12345678};
        vt[8]  = '{1'b1, 1'b0, 4'b0000, 4'd7, 32'h0,        1'b0, 32'h12345678};
        vt[9]  = '{1'b0, 1'b1, 4'b1111, 4'd7, 32'h0,        1'b1, 32'h12345678};
        vt[10] = '{1'b0, 1'b0, 4'b0000, 4'd5, 32'h00000055, 1'b0, 32'h12345678};
        vt[11] = '{1'b0, 1'b1, 4'b1111, 4'd5, 32'h0,        1'b1, 32'h00000055};

        rst = 1'b1;
        clr = 1'b0;
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h0);
        cyc();
        cyc();
        chk("rst_data", d0, 32'h0);
        chk("rst_valid", {31'b0, v0}, 32'h0);
        chk("rst_busy0", {31'b0, b0}, 32'h0);
        chk("rst_valid1", {31'b0, v1}, 32'h0);
        chk("rst_busy2", {31'b0, b2}, 32'h0);

        // Release reset; the no-init instance accepts accesses at once and ignores clr_i.
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'd9, 32'hDEADBEEF);
        clr = 1'b1;
        cyc();
        chk("noinit_busy_a", {31'b0, b2}, 32'h0);
        chk("init_busy_first", {31'b0, b0}, 32'h1);
        bc = b0 ? 1 : 0;
        drive(1'b0, 1'b1, 4'hF, 4'd9, 32'h0);
        clr = 1'b0;
        cyc();
        chk("noinit_valid", {31'b0, v2}, 32'h1);
        chk("noinit_data", d2, 32'hDEADBEEF);
        chk("noinit_busy_b", {31'b0, b2}, 32'h0);
        chk("busy_read_ignored", {31'b0, v0}, 32'h0);
        if (b0) bc++;
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!b0) break;
            bc++;
            chk("init_valid", {31'b0, v0}, 32'h0);
            chk("init_data", d0, 32'h0);
        end
        chk("init_busy_len", bc, 16);
        chk("init_done", {31'b0, b0}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'hF, AW'(i), 32'h0);
            cyc();
            chk($sformatf("zero_valid_a%0d", i), {31'b0, v0}, 32'h1);
            chk($sformatf("zero_data_a%0d", i), d0, 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].cen, vt[i].wen, vt[i].bwen, vt[i].addr, vt[i].data);
            cyc();
            chk($sformatf("vec%0d_valid", i), {31'b0, v0}, {31'b0, vt[i].exp_v});
            chk($sformatf("vec%0d_data", i), d0, vt[i].exp_d);
        end

        // Streaming reads through both latencies.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 4'h0, AW'(k), 32'h10 + 32'(k));
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 4'hF, AW'(k), 32'h0);
            cyc();
            chk($sformatf("l1_stream%0d", k), d0, 32'h10 + 32'(k));
            if (k == 0) begin
                chk("l2_stream_lat", {31'b0, v1}, 32'h0);
            end else begin
                chk($sformatf("l2_stream_v%0d", k), {31'b0, v1}, 32'h1);
                chk($sformatf("l2_stream_d%0d", k), d1, 32'h10 + 32'(k - 1));
            end
        end
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h0);
        cyc();
        chk("l2_stream_v4", {31'b0, v1}, 32'h1);
        chk("l2_stream_d4", d1, 32'h13);
        cyc();
        chk("l2_hold_valid", {31'b0, v1}, 32'h0);
        chk("l2_hold_data", d1, 32'h13);

        // Clear request coinciding with a read of addr 5.
        drive(1'b0, 1'b1, 4'hF, 4'd5, 32'h0);
        clr = 1'b1;
        cyc();
        chk("clr_read_valid", {31'b0, v0}, 32'h1);
        chk("clr_read_data", d0, 32'h55);
        chk("clr_busy", {31'b0, b0}, 32'h1);
        chk("clr_noinit_busy", {31'b0, b2}, 32'h0);
        clr = 1'b0;
        bc = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (i == 0) begin
                chk("l2_clr_valid", {31'b0, v1}, 32'h1);
                chk("l2_clr_data", d1, 32'h55);
                chk("l2_clr_busy", {31'b0, b1}, 32'h1);
            end
            if (!b0) break;
            bc++;
            chk("clr_busy_read", {31'b0, v0}, 32'h0);
        end
        chk("clr_busy_len", bc, 16);
        chk("clr_done", {31'b0, b0}, 32'h0);
        chk("clr_last_read", {31'b0, v0}, 32'h0);
        cyc();
        chk("post_clr_valid", {31'b0, v0}, 32'h1);
        chk("post_clr_data", d0, 32'h0);
        chk("noinit_kept_data", d2, 32'h55);

        // Reset in the middle of a clear: restart, full-length busy, outputs quiet.
        drive(1'b1, 1'b1, 4'hF, 4'd0, 32'h0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("mid_busy_start", {31'b0, b0}, 32'h1);
        for (int i = 0; i < 6; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("mid_rst_busy", {31'b0, b0}, 32'h0);
        chk("mid_rst_data", d0, 32'h0);
        chk("mid_rst_valid", {31'b0, v0}, 32'h0);
        rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!b0) break;
            bc++;
            chk("mid_valid", {31'b0, v0 | v1}, 32'h0);
            chk("mid_data", d0 | d1, 32'h0);
        end
        chk("mid_busy_len", bc, 16);
        drive(1'b0, 1'b1, 4'hF, 4'd3, 32'h0);
        cyc();
        chk("mid_final_valid", {31'b0, v0}, 32'h1);
        chk("mid_final_data", d0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
